// File: rtl/program_counter.sv
// Program-counter register: latches the upstream-selected next address each
// cycle and exposes the current fetch address plus its PC+INC successor.
module program_counter #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      INC        = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] Address_in,
  output logic [WIDTH-1:0] Address_out,
  output logic [WIDTH-1:0] Address_plus
);

  // PC state: reset forces RESET_ADDR at once; otherwise copy next address verbatim.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Address_out <= RESET_ADDR;
    end else begin
      Address_out <= Address_in;
    end
  end

  // Sequential successor for the fetch path; wraps modulo 2^WIDTH, no carry out.
  assign Address_plus = Address_out + WIDTH'(INC);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed reset/load/wrap scenarios
// plus randomized input toggling against a simple expected-PC model.
module tb_program_counter;

  localparam int unsigned W   = 32;
  localparam logic [W-1:0] RA = 32'h0000_0000;
  localparam logic [W-1:0] K  = 32'd4;

  logic         CLK;
  logic         RST_n;
  logic [W-1:0] Address_in;
  logic [W-1:0] Address_out;
  logic [W-1:0] Address_plus;

  int total;
  int bad;

  // Expected current PC, maintained by the stimulus sequence from the rules:
  // reset -> RA, otherwise the value Address_in held at the last rising edge.
  logic [W-1:0] exp_pc;

  program_counter #(
    .WIDTH      (W),
    .RESET_ADDR (RA),
    .INC        (4)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .Address_in   (Address_in),
    .Address_out  (Address_out),
    .Address_plus (Address_plus)
  );

  // Clock: rising edges at t = 10, 20, 30, ...
  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Compare both outputs against the expected PC.
  task automatic check_pc(input string tag, input logic [W-1:0] pc);
    check({tag, "_out"}, Address_out, pc);
    check({tag, "_plus"}, Address_plus, pc + K);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // Reset from time zero, released away from the first edge.
    RST_n      = 1'b0;
    Address_in = 32'h0000_0017;
    #1;
    exp_pc = RA;
    check_pc("reset_init", exp_pc);
    #2 RST_n = 1'b1;                      // t = 3

    // Edge at t = 10 loads 0x17.
    @(posedge CLK); #1;
    exp_pc = 32'h0000_0017;
    check_pc("first_load", exp_pc);

    // Mid-cycle async reset: takes effect before the next edge.
    #3 RST_n = 1'b0;                      // t = 14
    Address_in = 32'd34;
    #1;
    exp_pc = RA;
    check("async_reset_out", Address_out, 32'h0);
    check("async_reset_plus", Address_plus, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_pc("reset_hold", RA);
    end

    // Release at t = 44, load 23 on the edge at t = 50.
    #3 RST_n = 1'b1;
    Address_in = 32'd23;
    @(posedge CLK); #1;
    exp_pc = 32'd23;
    check("basic_load_out", Address_out, 32'd23);
    check("basic_load_plus", Address_plus, 32'd27);

    // Input changes between edges must not reach the outputs.
    Address_in = 32'd0;                   // edge + 1
    #1 check_pc("iso_a", 32'd23);
    #2 Address_in = 32'd1;                // edge + 4
    #1 check_pc("iso_b", 32'd23);
    @(posedge CLK); #1;
    exp_pc = 32'd1;
    check_pc("iso_load", exp_pc);

    // Random toggling in {0,1}, several changes per cycle; last value before the edge wins.
    for (int i = 0; i < 200; i++) begin
      Address_in = W'($urandom_range(0, 1));   // edge + 1
      #2 check_pc("rand01_mid", exp_pc);
      Address_in = W'($urandom_range(0, 1));   // edge + 3
      #3 Address_in = W'($urandom_range(0, 1)); // edge + 6
      exp_pc = Address_in;
      @(posedge CLK); #1;
      check_pc("rand01", exp_pc);
    end

    // Random full-width values, no alignment masking expected.
    for (int i = 0; i < 40; i++) begin
      #2 Address_in = $urandom();
      exp_pc = Address_in;
      @(posedge CLK); #1;
      check_pc("randw", exp_pc);
    end

    // Wrap-around of the successor output.
    #2 Address_in = 32'hFFFF_FFFC;
    @(posedge CLK); #1;
    check("wrap_fc_out", Address_out, 32'hFFFF_FFFC);
    check("wrap_fc_plus", Address_plus, 32'h0000_0000);
    #2 Address_in = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    check("wrap_ff_out", Address_out, 32'hFFFF_FFFF);
    check("wrap_ff_plus", Address_plus, 32'h0000_0003);

    // Reset asserted coincident with a rising edge: reset wins.
    @(negedge CLK);
    Address_in = 32'h0000_0100;
    #5 RST_n = 1'b0;                      // same timestep as the rising edge
    #1;
    check_pc("race_reset", RA);
    #3 RST_n = 1'b1;                      // released mid-cycle
    #1 check_pc("race_release_hold", RA);
    @(posedge CLK); #1;
    check_pc("race_reload", 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
